// File: rtl/scatter_pkg.sv
// Shared header for the gather/scatter pair: FSM states, the tag-width rule
// and the {tag, data} word packing used on the serial side.
package scatter_pkg;

   typedef enum logic {
      FILL  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   localparam int DEF_W = 8;
   localparam int DEF_N = 2;

   // Tag field width for an N-lane frame; N is always at least 2.
   function automatic int tagWidth(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Builds a serial word with the tag in the MSBs above a w-bit data field.
   function automatic logic [63:0] packWord(input int w, input logic [31:0] tag,
                                            input logic [31:0] data);
      logic [63:0] mask;
      mask = (64'd1 << w) - 64'd1;
      return ({32'd0, tag} << w) | ({32'd0, data} & mask);
   endfunction

endpackage

// File: rtl/scatter.sv
// Collects address-tagged serial words into an N-lane frame. The frame is
// released only once every lane holds a word, then each lane drains on its
// own valid/ready handshake before filling resumes.
module scatter
   import scatter_pkg::*;
#(
   parameter int W = DEF_W,
   parameter int N = DEF_N
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        s_stb,
   input  logic [tagWidth(N)+W-1:0]    s_dat,
   output logic                        s_rdy,
   output logic [N-1:0]                m_stb,
   output logic [N*W-1:0]              m_dat,
   input  logic [N-1:0]                m_rdy,
   output logic                        err
);

   localparam int TW = tagWidth(N);

   state_t           r_state;
   state_t           w_stateNext;
   logic [N*W-1:0]   r_lane;
   logic [N-1:0]     r_full;
   logic [N-1:0]     r_pend;
   logic             r_err;

   logic [TW-1:0]    w_tag;
   logic [W-1:0]     w_data;
   logic             w_fill;
   logic             w_accept;
   logic [N-1:0]     w_hit;
   logic             w_tagValid;
   logic [N-1:0]     w_fullNext;
   logic             w_dup;
   logic             w_bad;
   logic             w_frameDone;
   logic [N-1:0]     w_pendNext;

   assign w_tag      = s_dat[TW+W-1:W];
   assign w_data     = s_dat[W-1:0];
   assign w_fill     = (r_state == FILL) && rst;
   assign w_accept   = s_stb && w_fill;
   assign w_tagValid = |w_hit;
   assign w_fullNext = r_full | (w_accept ? w_hit : '0);
   assign w_dup      = w_accept && |(r_full & w_hit);
   assign w_bad      = w_accept && !w_tagValid;
   assign w_frameDone = w_accept && w_tagValid && (&w_fullNext);
   assign w_pendNext = r_pend & ~m_rdy;
   assign m_dat      = r_lane;
   assign err        = r_err;

   // One-hot tag decode; an out-of-range tag matches no lane.
   always_comb begin
      w_hit = '0;
      for (int i = 0; i < N; i++) begin
         w_hit[i] = (w_tag == TW'(i));
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= FILL;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Next-state and handshake outputs: ready to accept while filling, lane
   // valids follow the pending mask while draining.
   always_comb begin
      w_stateNext = r_state;
      s_rdy       = 1'b0;
      m_stb       = '0;
      case (r_state)
         FILL: begin
            s_rdy = w_fill;
            if (w_frameDone) begin
               w_stateNext = DRAIN;
            end
         end
         DRAIN: begin
            m_stb = r_pend;
            if (w_pendNext == '0) begin
               w_stateNext = FILL;
            end
         end
         default: begin
            w_stateNext = FILL;
         end
      endcase
   end

   // Lane file, full/pend masks and the error pulse; lanes are only written
   // while filling, so the frame stays stable throughout the drain.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_lane <= '0;
         r_full <= '0;
         r_pend <= '0;
         r_err  <= 1'b0;
      end else begin
         r_err <= w_dup || w_bad;
         for (int i = 0; i < N; i++) begin
            if (w_accept && w_hit[i]) begin
               r_lane[i*W +: W] <= w_data;
            end
         end
         if (w_frameDone) begin
            r_full <= '0;
            r_pend <= {N{1'b1}};
         end else begin
            if (w_accept) begin
               r_full <= w_fullNext;
            end
            if (r_state == DRAIN) begin
               r_pend <= w_pendNext;
            end
         end
      end
   end

endmodule
